// File: rtl/gecko_mem_arbiter_if.sv
// gecko_mem_arbiter_if: one request/response port of the shared-memory arbiter.
// The master side issues requests and accepts responses; the slave side
// accepts requests and returns responses.
interface gecko_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_read;
    logic [DATA_WIDTH/8-1:0] req_wmask;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    res_valid;
    logic                    res_ready;
    logic [DATA_WIDTH-1:0]   res_data;

    modport master (
        output req_valid, req_addr, req_read, req_wmask, req_wdata, res_ready,
        input  req_ready, res_valid, res_data
    );

    modport slave (
        input  req_valid, req_addr, req_read, req_wmask, req_wdata, res_ready,
        output req_ready, res_valid, res_data
    );
endinterface

// File: rtl/gecko_mem_arbiter.sv
// gecko_mem_arbiter: shares one single-port memory between the core's
// instruction and data ports. Requests are granted round-robin and forwarded
// combinationally; a tag FIFO remembers which port issued each accepted
// request so in-order responses can be steered back to the right port.
// Optional macro GECKO_MEM_ARBITER_STATS_EN adds grant and conflict counters.
module gecko_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    gecko_mem_arbiter_if.slave         inst,
    gecko_mem_arbiter_if.slave         data,
    gecko_mem_arbiter_if.master        mem,
    output logic                       orphan_flag
`ifdef GECKO_MEM_ARBITER_STATS_EN
    ,
    output logic [31:0]                inst_grant_count,
    output logic [31:0]                data_grant_count,
    output logic [31:0]                conflict_count
`endif
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic                       last_grant;
    logic                       held_grant;
    logic                       grant_data;
    logic                       req_valid_int;
    logic                       res_ready_int;
    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       head_tag;
    logic                       push;
    logic                       pop;
    logic                       orphan_hit;

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign head_tag   = tag_mem[rd_ptr];

    // Pick the granted port, drive the memory request mux and request readies, and decide HOLD entry/exit.
    always_comb begin
        state_next     = state;
        grant_data     = 1'b0;
        req_valid_int  = 1'b0;
        push           = 1'b0;
        mem.req_valid  = 1'b0;
        mem.req_addr   = '0;
        mem.req_read   = 1'b0;
        mem.req_wmask  = '0;
        mem.req_wdata  = '0;
        inst.req_ready = 1'b0;
        data.req_ready = 1'b0;
        if (state == HOLD) begin
            grant_data = held_grant;
        end else if (inst.req_valid && data.req_valid) begin
            grant_data = ~last_grant;
        end else begin
            grant_data = data.req_valid;
        end
        if (rst) begin
            if (grant_data) begin
                req_valid_int = data.req_valid && !fifo_full;
                mem.req_addr  = data.req_addr;
                mem.req_read  = data.req_read;
                mem.req_wmask = data.req_wmask;
                mem.req_wdata = data.req_wdata;
            end else begin
                req_valid_int = inst.req_valid && !fifo_full;
                mem.req_addr  = inst.req_addr;
                mem.req_read  = inst.req_read;
                mem.req_wmask = inst.req_wmask;
                mem.req_wdata = inst.req_wdata;
            end
            mem.req_valid  = req_valid_int;
            inst.req_ready = !grant_data && mem.req_ready && !fifo_full;
            data.req_ready = grant_data && mem.req_ready && !fifo_full;
            push           = req_valid_int && mem.req_ready;
            if (state == IDLE && req_valid_int && !mem.req_ready) begin
                state_next = HOLD;
            end else if (state == HOLD && push) begin
                state_next = IDLE;
            end
        end
    end

    // Steer the memory response to the port named by the FIFO head; swallow responses nobody asked for.
    always_comb begin
        inst.res_valid = 1'b0;
        data.res_valid = 1'b0;
        inst.res_data  = '0;
        data.res_data  = '0;
        res_ready_int  = 1'b0;
        pop            = 1'b0;
        orphan_hit     = 1'b0;
        if (rst) begin
            inst.res_data = mem.res_data;
            data.res_data = mem.res_data;
            if (!fifo_empty) begin
                inst.res_valid = mem.res_valid && !head_tag;
                data.res_valid = mem.res_valid && head_tag;
                res_ready_int  = head_tag ? data.res_ready : inst.res_ready;
                pop            = mem.res_valid && res_ready_int;
            end else begin
                res_ready_int = 1'b1;
                orphan_hit    = mem.res_valid;
            end
        end
        mem.res_ready = res_ready_int;
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Freeze the grant while idle-to-hold, and remember the last winner for round-robin ties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
            held_grant <= 1'b0;
        end else begin
            if (state == IDLE) begin
                held_grant <= grant_data;
            end
            if (push) begin
                last_grant <= grant_data;
            end
        end
    end

    // Tag FIFO: push the requester id on each accepted request, pop on each routed response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= grant_data;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for a response that arrived with nothing outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            orphan_flag <= 1'b0;
        end else if (orphan_hit) begin
            orphan_flag <= 1'b1;
        end
    end

`ifdef GECKO_MEM_ARBITER_STATS_EN
    // Free-running statistics: accepted grants per port and cycles with both ports requesting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_grant_count <= '0;
            data_grant_count <= '0;
            conflict_count   <= '0;
        end else begin
            if (push && !grant_data) begin
                inst_grant_count <= inst_grant_count + 32'd1;
            end
            if (push && grant_data) begin
                data_grant_count <= data_grant_count + 32'd1;
            end
            if (inst.req_valid && data.req_valid) begin
                conflict_count <= conflict_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gecko_mem_arbiter.sv
// tb_gecko_mem_arbiter: directed test of the shared-memory arbiter with a
// queue-based reference model checked against the DUT on every falling edge.
module tb_gecko_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic orphan_flag;
`ifdef GECKO_MEM_ARBITER_STATS_EN
    logic [31:0] inst_grant_count;
    logic [31:0] data_grant_count;
    logic [31:0] conflict_count;
`endif

    always #5 clk = ~clk;

    gecko_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) inst_if ();
    gecko_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) data_if ();
    gecko_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    gecko_mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inst(inst_if),
        .data(data_if),
        .mem(mem_if),
        .orphan_flag(orphan_flag)
`ifdef GECKO_MEM_ARBITER_STATS_EN
        ,
        .inst_grant_count(inst_grant_count),
        .data_grant_count(data_grant_count),
        .conflict_count(conflict_count)
`endif
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: outstanding requester ids in order, last winner, held grant, orphan flag.
    int tag_q[$];
    int grant_log[$];
    int resp_log[$];
    int model_last = 1;
    bit model_hold = 1'b0;
    int model_hold_port = 0;
    bit model_orphan = 1'b0;
    int inst_xfers = 0;
    int data_xfers = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic iv, input logic [AW-1:0] ia,
                                 input logic dv, input logic [AW-1:0] da,
                                 input logic mrr, input logic mrv, input logic [DW-1:0] mrd,
                                 input logic irr, input logic drr);
        @(posedge clk);
        #1;
        rst               = r;
        inst_if.req_valid = iv;
        inst_if.req_addr  = ia;
        inst_if.req_read  = 1'b1;
        inst_if.req_wmask = '0;
        inst_if.req_wdata = '0;
        data_if.req_valid = dv;
        data_if.req_addr  = da;
        data_if.req_read  = 1'b0;
        data_if.req_wmask = 4'hF;
        data_if.req_wdata = 32'hC0DE0000 ^ da;
        mem_if.req_ready  = mrr;
        mem_if.res_valid  = mrv;
        mem_if.res_data   = mrd;
        inst_if.res_ready = irr;
        data_if.res_ready = drr;
        #1;
    endtask

    task automatic idleStep();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    endtask

    // Compare the DUT against the model mid-cycle, then advance the model by the transfers of this cycle.
    task automatic modelCompare();
        int g;
        int head;
        bit full;
        bit gv;
        bit exp_mv;
        bit exp_rr;
        if (!rst) begin
            checkOutput("rst_mem_req_valid", mem_if.req_valid, 0);
            checkOutput("rst_inst_req_ready", inst_if.req_ready, 0);
            checkOutput("rst_data_req_ready", data_if.req_ready, 0);
            checkOutput("rst_inst_res_valid", inst_if.res_valid, 0);
            checkOutput("rst_data_res_valid", data_if.res_valid, 0);
            checkOutput("rst_mem_res_ready", mem_if.res_ready, 0);
            checkOutput("rst_orphan_flag", orphan_flag, 0);
            checkOutput("rst_mem_req_addr", mem_if.req_addr, 0);
            checkOutput("rst_inst_res_data", inst_if.res_data, 0);
            tag_q.delete();
            model_last   = 1;
            model_hold   = 1'b0;
            model_orphan = 1'b0;
            return;
        end
        full = (tag_q.size() == MAXO);
        if (model_hold) g = model_hold_port;
        else if (inst_if.req_valid && data_if.req_valid) g = 1 - model_last;
        else if (data_if.req_valid) g = 1;
        else g = 0;
        gv     = (g == 1) ? data_if.req_valid : inst_if.req_valid;
        exp_mv = gv && !full;
        checkOutput("mem_req_valid", mem_if.req_valid, exp_mv);
        if (inst_if.req_valid || data_if.req_valid) begin
            checkOutput("inst_req_ready", inst_if.req_ready, (g == 0) && mem_if.req_ready && !full);
            checkOutput("data_req_ready", data_if.req_ready, (g == 1) && mem_if.req_ready && !full);
        end
        if (exp_mv) begin
            checkOutput("mem_req_addr", mem_if.req_addr, (g == 1) ? data_if.req_addr : inst_if.req_addr);
            checkOutput("mem_req_read", mem_if.req_read, (g == 1) ? data_if.req_read : inst_if.req_read);
            checkOutput("mem_req_wmask", mem_if.req_wmask, (g == 1) ? data_if.req_wmask : inst_if.req_wmask);
            checkOutput("mem_req_wdata", mem_if.req_wdata, (g == 1) ? data_if.req_wdata : inst_if.req_wdata);
        end
        if (tag_q.size() > 0) begin
            head   = tag_q[0];
            exp_rr = (head == 1) ? data_if.res_ready : inst_if.res_ready;
            checkOutput("inst_res_valid", inst_if.res_valid, mem_if.res_valid && (head == 0));
            checkOutput("data_res_valid", data_if.res_valid, mem_if.res_valid && (head == 1));
        end else begin
            exp_rr = 1'b1;
            checkOutput("inst_res_valid_empty", inst_if.res_valid, 0);
            checkOutput("data_res_valid_empty", data_if.res_valid, 0);
        end
        checkOutput("mem_res_ready", mem_if.res_ready, exp_rr);
        checkOutput("inst_res_data", inst_if.res_data, mem_if.res_data);
        checkOutput("data_res_data", data_if.res_data, mem_if.res_data);
        checkOutput("orphan_flag", orphan_flag, model_orphan);
        if (mem_if.res_valid && exp_rr) begin
            if (tag_q.size() > 0) begin
                resp_log.push_back(tag_q[0]);
                void'(tag_q.pop_front());
            end else begin
                model_orphan = 1'b1;
            end
        end
        if (exp_mv && mem_if.req_ready) begin
            tag_q.push_back(g);
            grant_log.push_back(g);
            model_last = g;
            model_hold = 1'b0;
        end else if (exp_mv) begin
            model_hold      = 1'b1;
            model_hold_port = g;
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        modelCompare();
    end

    // Count accepted requests per port as seen on the DUT handshake.
    always @(posedge clk) begin
        if (rst && inst_if.req_valid && inst_if.req_ready) inst_xfers++;
        if (rst && data_if.req_valid && data_if.req_ready) data_xfers++;
    end

    initial begin
        inst_if.req_valid = 1'b0; inst_if.req_addr = '0; inst_if.req_read = 1'b0;
        inst_if.req_wmask = '0;   inst_if.req_wdata = '0; inst_if.res_ready = 1'b0;
        data_if.req_valid = 1'b0; data_if.req_addr = '0; data_if.req_read = 1'b0;
        data_if.req_wmask = '0;   data_if.req_wdata = '0; data_if.res_ready = 1'b0;
        mem_if.req_ready  = 1'b0; mem_if.res_valid = 1'b0; mem_if.res_data = '0;

        // Reset state
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 1'b1, 32'h1234, 1'b1, 1'b1);
        checkOutput("reset_mem_req_valid", mem_if.req_valid, 0);
        checkOutput("reset_inst_req_ready", inst_if.req_ready, 0);
        checkOutput("reset_orphan", orphan_flag, 0);
        idleStep();

        // Single instruction read, response next cycle
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("t1_mem_req_valid", mem_if.req_valid, 1);
        checkOutput("t1_mem_req_addr", mem_if.req_addr, 32'h100);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        checkOutput("t1_inst_res_valid", inst_if.res_valid, 1);
        checkOutput("t1_inst_res_data", inst_if.res_data, 32'hDEADBEEF);
        checkOutput("t1_data_res_valid", data_if.res_valid, 0);
        idleStep();

        // Round-robin with both ports requesting, after a fresh reset
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idleStep();
        grant_log.delete();
        resp_log.delete();
        inst_xfers = 0;
        data_xfers = 0;
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b1, c < 6, 32'h200, c < 6, 32'h300, 1'b1, c > 0, 32'hA0 + c, 1'b1, 1'b1);
            if (c == 0) checkOutput("t2_first_inst_ready", inst_if.req_ready, 1);
            if (c == 1) begin
                checkOutput("t2_c1_data_ready", data_if.req_ready, 1);
                checkOutput("t2_c1_inst_res_valid", inst_if.res_valid, 1);
            end
            if (c == 2) checkOutput("t2_c2_data_res_valid", data_if.res_valid, 1);
        end
        idleStep();
        checkOutput("t2_grant_count", grant_log.size(), 6);
        checkOutput("t2_resp_count", resp_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) checkOutput("t2_grant_order", grant_log[i], i % 2);
            if (i < resp_log.size()) checkOutput("t2_resp_order", resp_log[i], i % 2);
        end
        checkOutput("t2_inst_xfers", inst_xfers, 3);
        checkOutput("t2_data_xfers", data_xfers, 3);

        // Memory stalls an instruction request while data arrives
        applyStimulus(1'b1, 1'b1, 32'h400, 1'b0, 32'h500, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("t3_a_mem_req_valid", mem_if.req_valid, 1);
        checkOutput("t3_a_addr", mem_if.req_addr, 32'h400);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 1'b0, '0, 1'b1, 1'b1);
            checkOutput("t3_hold_addr", mem_if.req_addr, 32'h400);
            checkOutput("t3_hold_data_ready", data_if.req_ready, 0);
        end
        applyStimulus(1'b1, 1'b1, 32'h400, 1'b1, 32'h500, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("t3_d_inst_ready", inst_if.req_ready, 1);
        checkOutput("t3_d_data_ready", data_if.req_ready, 0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 32'h500, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("t3_e_data_ready", data_if.req_ready, 1);
        checkOutput("t3_e_addr", mem_if.req_addr, 32'h500);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h111, 1'b1, 1'b1);
        checkOutput("t3_f_inst_res_valid", inst_if.res_valid, 1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h222, 1'b1, 1'b1);
        checkOutput("t3_g_data_res_valid", data_if.res_valid, 1);
        checkOutput("t3_g_data_res_data", data_if.res_data, 32'h222);
        idleStep();

        // Fill the tag FIFO, then free one slot
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, 32'h700 + 4 * k, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        end
        applyStimulus(1'b1, 1'b1, 32'h710, 1'b1, 32'h800, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("t4_full_inst_ready", inst_if.req_ready, 0);
        checkOutput("t4_full_data_ready", data_if.req_ready, 0);
        checkOutput("t4_full_mem_req_valid", mem_if.req_valid, 0);
        applyStimulus(1'b1, 1'b1, 32'h710, 1'b1, 32'h800, 1'b1, 1'b1, 32'h333, 1'b1, 1'b1);
        checkOutput("t4_pop_cycle_data_ready", data_if.req_ready, 0);
        checkOutput("t4_pop_cycle_inst_res_valid", inst_if.res_valid, 1);
        applyStimulus(1'b1, 1'b1, 32'h710, 1'b1, 32'h800, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("t4_after_pop_data_ready", data_if.req_ready, 1);
        checkOutput("t4_after_pop_addr", mem_if.req_addr, 32'h800);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h900 + k, 1'b1, 1'b1);
            if (k == 3) checkOutput("t4_drain_data_res_valid", data_if.res_valid, 1);
        end
        idleStep();

        // Data response held off by the data port
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 32'h900, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h55, 1'b1, 1'b0);
            checkOutput("t5_stall_mem_res_ready", mem_if.res_ready, 0);
            checkOutput("t5_stall_data_res_valid", data_if.res_valid, 1);
            checkOutput("t5_stall_inst_res_valid", inst_if.res_valid, 0);
        end
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h55, 1'b1, 1'b1);
        checkOutput("t5_release_mem_res_ready", mem_if.res_ready, 1);
        idleStep();

        // Orphan response, then reset in the middle of a burst
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'hBAD, 1'b1, 1'b1);
        checkOutput("t6_orphan_res_ready", mem_if.res_ready, 1);
        checkOutput("t6_orphan_inst_res_valid", inst_if.res_valid, 0);
        idleStep();
        checkOutput("t6_orphan_flag", orphan_flag, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 32'hA00 + 4 * k, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 32'hA0C, 1'b1, 32'hB00, 1'b1, 1'b1, 32'h77, 1'b1, 1'b1);
        checkOutput("t6_rst_mem_req_valid", mem_if.req_valid, 0);
        checkOutput("t6_rst_inst_res_valid", inst_if.res_valid, 0);
        checkOutput("t6_rst_mem_res_ready", mem_if.res_ready, 0);
        checkOutput("t6_rst_orphan_flag", orphan_flag, 0);
        checkOutput("t6_rst_res_data", inst_if.res_data, 0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h88, 1'b1, 1'b1);
        checkOutput("t6_post_rst_empty_res_ready", mem_if.res_ready, 1);
        checkOutput("t6_post_rst_inst_res_valid", inst_if.res_valid, 0);
        idleStep();
        idleStep();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
